// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned INSTR_WIDTH = 32;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush; head word is read combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        data,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]        head
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      occ;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ == FULL_COUNT);
  assign empty   = (occ == '0);
  assign count   = occ;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/risc_v_fetch_unit.sv
// Decoupled fetch front end: credit-limited pipelined requests, in-order
// response buffering, and redirect handling that discards in-flight responses.
module risc_v_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       XLEN       = 32,
  parameter logic [XLEN-1:0]   RESET_ADDR = '0,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_addr,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [INSTR_WIDTH-1:0] dec_instruction,
  output logic [XLEN-1:0]        dec_pc
);

  localparam int unsigned     CW        = clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] STEP      = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN     = ~XLEN'(INSTR_BYTES - 1);

  logic [XLEN-1:0]        fetch_pc;
  logic [XLEN-1:0]        out_pc;
  logic [XLEN-1:0]        redirect_pc;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          drop;
  logic [CW-1:0]          count;
  logic                   credit;
  logic                   req_fire;
  logic                   rsp_keep;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [INSTR_WIDTH-1:0] head;

  // Occupancy plus outstanding requests never exceeds the buffer, so every
  // accepted request has a guaranteed slot when its response returns.
  assign credit         = ({1'b0, inflight} + {1'b0, count}) < DEPTH_EXT;
  assign imem_req_valid = reset && credit && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop == '0) && !redirect_valid;

  assign dec_valid       = !fifo_empty && !redirect_valid;
  assign pop             = dec_valid && dec_ready;
  assign dec_instruction = head;
  assign dec_pc          = out_pc;
  assign redirect_pc     = redirect_addr & ALIGN;

  fetch_fifo #(
    .WIDTH (INSTR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rsp_keep),
    .pop   (pop),
    .flush (redirect_valid),
    .data  (imem_rsp_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_ADDR;
      out_pc   <= RESET_ADDR;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      // Every still-outstanding request is now doomed; a response arriving
      // this very cycle is one of them and is discarded immediately.
      fetch_pc <= redirect_pc;
      out_pc   <= redirect_pc;
      inflight <= inflight - CW'(imem_rsp_valid);
      drop     <= inflight - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + STEP;
      if (pop)      out_pc   <= out_pc + STEP;
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
    end
  end

  rsp_needs_request: assert property (@(posedge clock) disable iff (!reset)
    imem_rsp_valid |-> (inflight != '0));

  rsp_has_space: assert property (@(posedge clock) disable iff (!reset)
    rsp_keep |-> !fifo_full);

endmodule

// File: tb/tb_risc_v_fetch_unit.sv
// Directed bench for risc_v_fetch_unit with a fixed-latency in-order memory.
module tb_risc_v_fetch_unit;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instruction;
  logic [31:0] dec_pc;

  int checks   = 0;
  int failures = 0;

  risc_v_fetch_unit #(
    .XLEN       (32),
    .RESET_ADDR (32'h0),
    .FIFO_DEPTH (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instruction (dec_instruction),
    .dec_pc          (dec_pc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory: a request accepted at edge n is answered at edge n+lat.
  // Decisions are made on the falling edge for the following rising edge.
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  req_t        pending[$];
  int unsigned edge_n   = 0;
  int unsigned last_due = 0;
  int unsigned lat      = 1;
  int unsigned accepted = 0;

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
  end

  always @(negedge clock) begin
    int unsigned d;
    edge_n = edge_n + 1;
    imem_rsp_valid = 1'b0;
    if (!reset) begin
      pending.delete();
      accepted = 0;
    end else begin
      if (pending.size() > 0 && pending[0].due <= edge_n) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1300_0000 | pending[0].addr;
        void'(pending.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        d = edge_n + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        pending.push_back('{addr: imem_req_addr, due: d});
        accepted = accepted + 1;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    step();
    step();
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_dec_valid", 32'(dec_valid), 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);

    // Single-cycle memory, decoder always ready: one instruction per cycle.
    reset = 1'b1;
    #1;
    chk("t1_first_valid", 32'(imem_req_valid), 1);
    chk("t1_first_addr", imem_req_addr, 32'h0);
    step();
    chk("t1_addr1", imem_req_addr, 32'h4);
    chk("t1_dec_valid0", 32'(dec_valid), 0);
    step();
    chk("t1_addr2", imem_req_addr, 32'h8);
    chk("t1_dec_valid1", 32'(dec_valid), 1);
    chk("t1_pc0", dec_pc, 32'h0);
    chk("t1_instr0", dec_instruction, 32'h1300_0000);
    step();
    chk("t1_addr3", imem_req_addr, 32'hC);
    chk("t1_pc1", dec_pc, 32'h4);
    chk("t1_instr1", dec_instruction, 32'h1300_0004);
    step();
    chk("t1_addr4", imem_req_addr, 32'h10);
    chk("t1_pc2", dec_pc, 32'h8);
    imem_req_ready = 1'b0;
    step();
    chk("t1_stall_addr", imem_req_addr, 32'h10);
    chk("t1_pc3", dec_pc, 32'hC);
    imem_req_ready = 1'b1;
    step();
    chk("t1_bubble", 32'(dec_valid), 0);
    step();
    chk("t1_pc4", dec_pc, 32'h10);

    // Decoder stalled: credit allows exactly FIFO_DEPTH requests.
    reset = 1'b0;
    step();
    dec_ready = 1'b0;
    reset = 1'b1;
    repeat (6) step();
    chk("t2_accepted4", accepted, 4);
    chk("t2_req_blocked", 32'(imem_req_valid), 0);
    chk("t2_head_pc", dec_pc, 32'h0);
    chk("t2_head_instr", dec_instruction, 32'h1300_0000);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    #1;
    chk("t2_pc_after_pop", dec_pc, 32'h4);
    chk("t2_req_reopen", 32'(imem_req_valid), 1);
    chk("t2_req_addr", imem_req_addr, 32'h10);
    step();
    chk("t2_accepted5", accepted, 5);
    chk("t2_req_blocked2", 32'(imem_req_valid), 0);
    step();
    dec_ready = 1'b1;
    #1;
    chk("t2_order0", dec_pc, 32'h4);
    step();
    chk("t2_order1", dec_pc, 32'h8);
    step();
    chk("t2_order2", dec_pc, 32'hC);
    step();
    chk("t2_order3", dec_pc, 32'h10);
    step();
    chk("t2_order4", dec_pc, 32'h14);
    chk("t2_order4_instr", dec_instruction, 32'h1300_0014);

    // Three-cycle memory, redirect with three requests outstanding.
    reset = 1'b0;
    step();
    lat = 3;
    reset = 1'b1;
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h100;
    #1;
    chk("t3_redir_req_gated", 32'(imem_req_valid), 0);
    chk("t3_redir_dec_gated", 32'(dec_valid), 0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t3_new_addr", imem_req_addr, 32'h100);
    chk("t3_new_valid", 32'(imem_req_valid), 1);
    chk("t3_dec_empty", 32'(dec_valid), 0);
    step();
    chk("t3_drop_a", 32'(dec_valid), 0);
    step();
    chk("t3_drop_b", 32'(dec_valid), 0);
    step();
    chk("t3_wait", 32'(dec_valid), 0);
    step();
    chk("t3_dec_valid", 32'(dec_valid), 1);
    chk("t3_dec_pc", dec_pc, 32'h100);
    chk("t3_dec_instr", dec_instruction, 32'h1300_0100);

    // Redirect coinciding with a response and a ready decoder; unaligned target.
    redirect_valid = 1'b1;
    redirect_addr  = 32'h203;
    #1;
    chk("t4_no_pop_dec", 32'(dec_valid), 0);
    chk("t4_no_req", 32'(imem_req_valid), 0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t5_aligned_addr", imem_req_addr, 32'h200);
    chk("t4_flushed", 32'(dec_valid), 0);
    step();
    chk("t4_drop_a", 32'(dec_valid), 0);
    step();
    chk("t4_drop_b", 32'(dec_valid), 0);
    step();
    chk("t4_wait", 32'(dec_valid), 0);
    step();
    chk("t5_dec_valid", 32'(dec_valid), 1);
    chk("t5_dec_pc", dec_pc, 32'h200);
    chk("t5_dec_instr", dec_instruction, 32'h1300_0200);

    // Mid-operation reset with two buffered words and one request outstanding.
    reset = 1'b0;
    step();
    lat = 1;
    dec_ready = 1'b0;
    reset = 1'b1;
    step();
    step();
    step();
    chk("t6_buffered", 32'(dec_valid), 1);
    chk("t6_pre_addr", imem_req_addr, 32'hC);
    reset = 1'b0;
    #1;
    chk("t6_req_valid", 32'(imem_req_valid), 0);
    chk("t6_dec_valid", 32'(dec_valid), 0);
    chk("t6_req_addr", imem_req_addr, 32'h0);
    chk("t6_dec_pc", dec_pc, 32'h0);
    step();
    reset = 1'b1;
    dec_ready = 1'b1;
    #1;
    chk("t6_restart_addr", imem_req_addr, 32'h0);
    chk("t6_restart_valid", 32'(imem_req_valid), 1);
    step();
    step();
    chk("t6_restart_pc", dec_pc, 32'h0);
    chk("t6_restart_instr", dec_instruction, 32'h1300_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
